// File: rtl/sdram_write_if.sv
// Handshake and SDRAM write-bus signals between sdram_write and its arbiter, write FIFO and pad logic.
interface sdram_write_if;
    logic        wr_trig;
    logic        wr_en;
    logic        aref_req;
    logic        wr_req;
    logic        flag_wr_end;
    logic [3:0]  wr_cmd;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_data_oe;
    logic        wfifo_rd_en;
    logic [15:0] wfifo_rd_data;

    modport master (
        input  wr_trig, wr_en, aref_req, wfifo_rd_data,
        output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data, wr_data_oe, wfifo_rd_en
    );

    modport slave (
        output wr_trig, wr_en, aref_req, wfifo_rd_data,
        input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_data, wr_data_oe, wfifo_rd_en
    );
endinterface

// File: rtl/sdram_write.sv
// SDRAM write sequencer: ACT / burst WRITE / PALL over ROW_END rows of COL_END bursts,
// yielding the bus to refresh at burst boundaries and resuming where it stopped.
module sdram_write #(
    parameter int unsigned BURST_END = 4,
    parameter int unsigned COL_END   = 2,
    parameter int unsigned ROW_END   = 2,
    parameter int unsigned T_RCD     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sdram_write_if.master bus
);
    localparam int unsigned BURST_W = 2;
    localparam int unsigned COL_W   = 8;
    localparam int unsigned ROW_W   = 13;
    localparam int unsigned ACT_W   = 3;
    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned DATA_W  = 16;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PALL = 4'b0010;

    localparam logic [ADDR_W-1:0]  ADDR_IDLE  = 13'h0400;
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_END - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COL_END - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROW_END - 1);
    localparam logic [ACT_W-1:0]   ACT_LAST   = ACT_W'(T_RCD - 1);

    typedef enum logic [4:0] {
        WR_IDLE   = 5'b00001,
        WR_REQ    = 5'b00010,
        WR_ACTIVE = 5'b00100,
        WR_WRITE  = 5'b01000,
        WR_BREAK  = 5'b10000
    } state_t;

    state_t               state_c, state_n;
    logic [BURST_W-1:0]   burst_cnt, burst_n;
    logic [COL_W-1:0]     col_cnt, col_n;
    logic [ROW_W-1:0]     row_cnt, row_n;
    logic [ACT_W-1:0]     act_cnt, act_n;
    logic                 brk_end, brk_end_n;
    logic                 brk_aref, brk_aref_n;

    logic [3:0]           cmd_q, cmd_n;
    logic [ADDR_W-1:0]    addr_q, addr_n;
    logic                 oe_q, oe_n;
    logic                 req_q, req_n;
    logic                 flag_q, flag_n;

    logic                 last_beat, col_last, row_last;

    assign last_beat = (burst_cnt == BURST_LAST);
    assign col_last  = (col_cnt == COL_LAST);
    assign row_last  = (row_cnt == ROW_LAST);

    // Next state and counters; the break reasons are latched on the burst's last beat.
    always_comb begin
        state_n    = state_c;
        burst_n    = burst_cnt;
        col_n      = col_cnt;
        row_n      = row_cnt;
        act_n      = act_cnt;
        brk_end_n  = brk_end;
        brk_aref_n = brk_aref;
        unique case (state_c)
            WR_IDLE: begin
                if (bus.wr_trig) state_n = WR_REQ;
            end
            WR_REQ: begin
                if (bus.wr_en) begin
                    state_n = WR_ACTIVE;
                    act_n   = '0;
                end
            end
            WR_ACTIVE: begin
                if (act_cnt == ACT_LAST) begin
                    state_n = WR_WRITE;
                    act_n   = '0;
                    burst_n = '0;
                end else begin
                    act_n = act_cnt + 3'd1;
                end
            end
            WR_WRITE: begin
                if (last_beat) begin
                    burst_n    = '0;
                    col_n      = col_last ? '0 : col_cnt + 8'd1;
                    if (col_last) row_n = row_last ? '0 : row_cnt + 13'd1;
                    brk_end_n  = col_last && row_last;
                    brk_aref_n = bus.aref_req;
                    if (bus.aref_req || col_last) state_n = WR_BREAK;
                end else begin
                    burst_n = burst_cnt + 2'd1;
                end
            end
            WR_BREAK: begin
                if (brk_end) begin
                    state_n = WR_IDLE;
                    burst_n = '0;
                    col_n   = '0;
                    row_n   = '0;
                end else if (brk_aref) begin
                    state_n = WR_REQ;
                end else begin
                    state_n = WR_ACTIVE;
                    act_n   = '0;
                end
            end
            default: state_n = WR_IDLE;
        endcase
    end

    // Output decode from next-cycle values so the registered bus lines up with state_c.
    always_comb begin
        cmd_n  = CMD_NOP;
        addr_n = ADDR_IDLE;
        oe_n   = 1'b0;
        req_n  = (state_n == WR_REQ);
        flag_n = 1'b0;
        if (state_n == WR_ACTIVE) begin
            if (act_n == '0) begin
                cmd_n  = CMD_ACT;
                addr_n = row_n;
            end
        end else if (state_n == WR_WRITE) begin
            cmd_n  = (burst_n == '0) ? CMD_WR : CMD_NOP;
            addr_n = {3'b000, col_n, burst_n};
            oe_n   = 1'b1;
        end else if (state_n == WR_BREAK) begin
            cmd_n  = CMD_PALL;
            flag_n = brk_end_n || brk_aref_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_c   <= WR_IDLE;
            burst_cnt <= '0;
            col_cnt   <= '0;
            row_cnt   <= '0;
            act_cnt   <= '0;
            brk_end   <= 1'b0;
            brk_aref  <= 1'b0;
            cmd_q     <= CMD_NOP;
            addr_q    <= ADDR_IDLE;
            oe_q      <= 1'b0;
            req_q     <= 1'b0;
            flag_q    <= 1'b0;
        end else begin
            state_c   <= state_n;
            burst_cnt <= burst_n;
            col_cnt   <= col_n;
            row_cnt   <= row_n;
            act_cnt   <= act_n;
            brk_end   <= brk_end_n;
            brk_aref  <= brk_aref_n;
            cmd_q     <= cmd_n;
            addr_q    <= addr_n;
            oe_q      <= oe_n;
            req_q     <= req_n;
            flag_q    <= flag_n;
        end
    end

    // FIFO read data arrives in the beat cycle itself, so the pop and the data mux stay combinational.
    assign bus.wfifo_rd_en = (state_n == WR_WRITE);
    assign bus.wr_data     = oe_q ? bus.wfifo_rd_data : DATA_W'(0);
    assign bus.wr_cmd      = cmd_q;
    assign bus.wr_addr     = addr_q;
    assign bus.wr_data_oe  = oe_q;
    assign bus.wr_req      = req_q;
    assign bus.flag_wr_end = flag_q;
endmodule

// File: tb/tb_sdram_write.sv
// Directed-vector bench for sdram_write: default instance plus a T_RCD=3 instance.
module tb_sdram_write;
    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] ACT  = 4'b0011;
    localparam logic [3:0] WR   = 4'b0100;
    localparam logic [3:0] PALL = 4'b0010;
    localparam logic [12:0] AI  = 13'h0400;

    typedef struct packed {
        logic        trig, en, aref;
        logic        req, flag;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic        oe, rd;
        logic [15:0] data;
    } vec_t;

    logic clk, rst_n, rst3_n;
    logic trig, en, aref;
    logic [15:0] fifo_q, fifo3_q;
    int unsigned fptr, fptr3;
    int errors = 0;
    int checks = 0;

    sdram_write_if bus();
    sdram_write_if bus3();

    assign bus.wr_trig        = trig;
    assign bus.wr_en          = en;
    assign bus.aref_req       = aref;
    assign bus.wfifo_rd_data  = fifo_q;
    assign bus3.wr_trig       = trig;
    assign bus3.wr_en         = en;
    assign bus3.aref_req      = aref;
    assign bus3.wfifo_rd_data = fifo3_q;

    sdram_write u_dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    sdram_write #(.T_RCD(3)) u_dut3 (.clk(clk), .rst_n(rst3_n), .bus(bus3.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write FIFO holding 0x0001, 0x0002, ...: data appears the cycle after a pop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q <= '0;
            fptr   <= 0;
        end else if (bus.wfifo_rd_en) begin
            fifo_q <= 16'(fptr + 1);
            fptr   <= fptr + 1;
        end
    end

    always @(posedge clk or negedge rst3_n) begin
        if (!rst3_n) begin
            fifo3_q <= '0;
            fptr3   <= 0;
        end else if (bus3.wfifo_rd_en) begin
            fifo3_q <= 16'(fptr3 + 1);
            fptr3   <= fptr3 + 1;
        end
    end

    function automatic vec_t mk(input logic t, input logic e, input logic a,
                                input logic rq, input logic fl, input logic [3:0] c,
                                input logic [12:0] ad, input logic o, input logic r,
                                input logic [15:0] d);
        vec_t v;
        v = '{trig: t, en: e, aref: a, req: rq, flag: fl, cmd: c, addr: ad, oe: o, rd: r, data: d};
        return v;
    endfunction

    function automatic logic [36:0] outs(input bit sel);
        if (sel)
            return {bus3.wr_req, bus3.flag_wr_end, bus3.wr_cmd, bus3.wr_addr,
                    bus3.wr_data_oe, bus3.wfifo_rd_en, bus3.wr_data};
        return {bus.wr_req, bus.flag_wr_end, bus.wr_cmd, bus.wr_addr,
                bus.wr_data_oe, bus.wfifo_rd_en, bus.wr_data};
    endfunction

    function automatic string fmt(input logic [36:0] o);
        return $sformatf("req=%b flag=%b cmd=%b addr=%h oe=%b rd_en=%b data=%h",
                         o[36], o[35], o[34:31], o[30:18], o[17], o[16], o[15:0]);
    endfunction

    // Drive one vector just after the rising edge, compare at the falling edge.
    task automatic apply(input vec_t v, input bit sel, input string name);
        logic [36:0] got, exp;
        trig = v.trig;
        en   = v.en;
        aref = v.aref;
        @(negedge clk);
        got = outs(sel);
        exp = {v.req, v.flag, v.cmd, v.addr, v.oe, v.rd, v.data};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[26];
    vec_t tbl2[26];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 1'b0;
        rst3_n = 1'b0;
        trig = 1'b0;
        en = 1'b0;
        aref = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full transfer, wr_en tied high: two rows, two bursts each.
        tbl[0] = mk(1, 1, 0, 0, 0, NOP, AI, 0, 0, 16'h0);
        tbl[1] = mk(0, 1, 0, 1, 0, NOP, AI, 0, 0, 16'h0);
        k = 2;
        for (int r = 0; r < 2; r++) begin
            tbl[k++] = mk(0, 1, 0, 0, 0, ACT, 13'(r), 0, 0, 16'h0);
            tbl[k++] = mk(0, 1, 0, 0, 0, NOP, AI, 0, 1, 16'h0);
            for (int b = 0; b < 8; b++)
                tbl[k++] = mk(0, 1, 0, 0, 0, (b % 4 == 0) ? WR : NOP, 13'(b), 1,
                              (b != 7), 16'(r * 8 + b + 1));
            tbl[k++] = mk(0, 1, 0, 0, (r == 1), PALL, AI, 0, 0, 16'h0);
        end
        tbl[k++] = mk(0, 1, 0, 0, 0, NOP, AI, 0, 0, 16'h0);
        tbl[k++] = mk(0, 1, 0, 0, 0, NOP, AI, 0, 0, 16'h0);

        do_reset();
        for (int i = 0; i < 26; i++) apply(tbl[i], 1'b0, $sformatf("xfer[%0d]", i));

        // Refresh pending on the transfer-end beat: still ends in IDLE.
        tbl2 = tbl;
        for (int i = 22; i < 26; i++) tbl2[i].aref = 1'b1;
        do_reset();
        for (int i = 0; i < 26; i++) apply(tbl2[i], 1'b0, $sformatf("aref_end[%0d]", i));

        // Grant withheld five cycles: hold in REQ without ACT or pop.
        do_reset();
        apply(mk(1, 0, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "nogrant_trig");
        for (int i = 0; i < 5; i++)
            apply(mk(0, 0, 0, 1, 0, NOP, AI, 0, 0, 16'h0), 1'b0, $sformatf("nogrant[%0d]", i));
        apply(mk(0, 1, 0, 1, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "grant");
        apply(mk(0, 1, 0, 0, 0, ACT, 13'h0, 0, 0, 16'h0), 1'b0, "grant_act");

        // Refresh raised at beat 1: burst completes, yields, then resumes at column 4.
        do_reset();
        apply(mk(1, 1, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "ref_trig");
        apply(mk(0, 1, 0, 1, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "ref_req");
        apply(mk(0, 1, 0, 0, 0, ACT, 13'h0, 0, 0, 16'h0), 1'b0, "ref_act");
        apply(mk(0, 1, 0, 0, 0, NOP, AI, 0, 1, 16'h0), 1'b0, "ref_nop");
        apply(mk(0, 1, 0, 0, 0, WR, 13'h0, 1, 1, 16'h1), 1'b0, "ref_b0");
        apply(mk(0, 1, 1, 0, 0, NOP, 13'h1, 1, 1, 16'h2), 1'b0, "ref_b1");
        apply(mk(1, 1, 1, 0, 0, NOP, 13'h2, 1, 1, 16'h3), 1'b0, "ref_b2");
        apply(mk(0, 1, 1, 0, 0, NOP, 13'h3, 1, 0, 16'h4), 1'b0, "ref_b3");
        apply(mk(0, 0, 0, 0, 1, PALL, AI, 0, 0, 16'h0), 1'b0, "ref_pall");
        apply(mk(0, 0, 0, 1, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "ref_wait");
        apply(mk(0, 1, 0, 1, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "ref_grant");
        apply(mk(0, 1, 0, 0, 0, ACT, 13'h0, 0, 0, 16'h0), 1'b0, "ref_act2");
        apply(mk(0, 1, 0, 0, 0, NOP, AI, 0, 1, 16'h0), 1'b0, "ref_nop2");
        apply(mk(0, 1, 0, 0, 0, WR, 13'h4, 1, 1, 16'h5), 1'b0, "ref_col4");
        apply(mk(0, 1, 0, 0, 0, NOP, 13'h5, 1, 1, 16'h6), 1'b0, "ref_col4_b1");

        // Reset dropped at beat 2: outputs collapse immediately, no PALL; restart from row 0.
        do_reset();
        for (int i = 0; i < 6; i++) apply(tbl[i], 1'b0, $sformatf("rst_pre[%0d]", i));
        rst_n = 1'b0;
        apply(mk(0, 1, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "rst_mid");
        apply(mk(0, 1, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "rst_hold");
        rst_n = 1'b1;
        apply(mk(0, 1, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b0, "rst_idle");
        for (int i = 0; i < 6; i++) apply(tbl[i], 1'b0, $sformatf("rst_post[%0d]", i));

        // T_RCD=3 instance: two NOPs between ACT and WRITE, pop in the second.
        apply(mk(0, 0, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b1, "t3_reset");
        rst3_n = 1'b1;
        apply(mk(0, 0, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b1, "t3_idle");
        apply(mk(1, 1, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b1, "t3_trig");
        apply(mk(0, 1, 0, 1, 0, NOP, AI, 0, 0, 16'h0), 1'b1, "t3_req");
        apply(mk(0, 1, 0, 0, 0, ACT, 13'h0, 0, 0, 16'h0), 1'b1, "t3_act");
        apply(mk(0, 1, 0, 0, 0, NOP, AI, 0, 0, 16'h0), 1'b1, "t3_nop1");
        apply(mk(0, 1, 0, 0, 0, NOP, AI, 0, 1, 16'h0), 1'b1, "t3_nop2");
        apply(mk(0, 1, 0, 0, 0, WR, 13'h0, 1, 1, 16'h1), 1'b1, "t3_write");
        apply(mk(0, 1, 0, 0, 0, NOP, 13'h1, 1, 1, 16'h2), 1'b1, "t3_b1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
